// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-256 definitions for the iterative cipher core.
//   - aes_block_t : 128-bit state / round-key block, byte 0 in bits [127:120],
//                   column-major (byte k is row k%4, column k/4).
//   - NR          : number of rounds for a 256-bit key.
//   - SBOX        : forward S-box ROM contents.
//   - rcon        : round-constant table (7 entries used by AES-256).
//   - xtime, rot_word, sub_word, shift_rows, mix_columns : round helpers.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam logic [3:0] NR = 4'd14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for the idx-th even-indexed key block; only 0..6 occur.
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = 8'h01;
      3'd1:    r = 8'h02;
      3'd2:    r = 8'h04;
      3'd3:    r = 8'h08;
      3'd4:    r = 8'h10;
      3'd5:    r = 8'h20;
      3'd6:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Row r is rotated left by r columns: out[r][c] = in[r][(c+r) mod 4].
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  // Each column multiplied by the circulant {02,03,01,01}.
  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t r;
    logic [7:0] b0, b1, b2, b3;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127 - 32*c -: 8];
      b1 = s[119 - 32*c -: 8];
      b2 = s[111 - 32*c -: 8];
      b3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 32] = {
        xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
        b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
        b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
        xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)
      };
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box (256-entry ROM lookup).
//   x : input byte
//   y : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  // ROM lookup of the substitution table.
  always_comb begin
    y = SBOX[x];
  end

endmodule

// File: rtl/aes_cipher.sv
// aes_cipher: iterative AES-256 encryptor, one round per clock, free running.
// A block is loaded every 15 cycles; the ciphertext is registered on dataout
// with a one-cycle done strobe.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   key     : 256-bit cipher key, byte 0 in [255:248]
//   datain  : 128-bit plaintext, byte 0 in [127:120]
//   dataout : registered ciphertext, held until the next block completes
//   done    : one-cycle pulse in the cycle dataout updates
module aes_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic [127:0] datain,
  output logic [127:0] dataout,
  output logic         done
);

  logic [3:0]   rnd_r;
  aes_block_t   state_r;
  logic [255:0] key_r;      // {A, B}: A = previous round key, B = current one
  aes_block_t   dataout_r;
  logic         done_r;

  aes_block_t   sb_s;
  aes_block_t   sr_s;
  aes_block_t   mc_s;
  aes_block_t   rk_s;
  logic         even_blk_s;
  logic [31:0]  sw_in_s;
  logic [31:0]  sw_s;
  logic [31:0]  t_s;
  logic [127:0] c_s;

  // Sixteen S-boxes for the SubBytes step on the state.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .x (state_r[127 - 8*i -: 8]),
      .y (sb_s[127 - 8*i -: 8])
    );
  end

  // Four S-boxes for SubWord in the key expansion.
  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .x (sw_in_s[31 - 8*j -: 8]),
      .y (sw_s[31 - 8*j -: 8])
    );
  end

  // Round datapath; the key used in round rnd is always the low half (B).
  always_comb begin
    rk_s = key_r[127:0];
    sr_s = shift_rows(sb_s);
    mc_s = mix_columns(sr_s);
  end

  // Select the SubWord input: odd rnd forms an even-indexed block and rotates.
  always_comb begin
    even_blk_s = rnd_r[0];
    if (even_blk_s) begin
      sw_in_s = rot_word(key_r[31:0]);
    end else begin
      sw_in_s = key_r[31:0];
    end
  end

  // Next key block C from A and the transformed last word of B.
  always_comb begin
    if (even_blk_s) begin
      // rnd = 2k+1 forms the k-th even-indexed block, so rnd[3:1] picks Rcon.
      t_s = sw_s ^ {rcon(rnd_r[3:1]), 24'h000000};
    end else begin
      t_s = sw_s;
    end
    c_s[127:96] = key_r[255:224] ^ t_s;
    c_s[95:64]  = key_r[223:192] ^ c_s[127:96];
    c_s[63:32]  = key_r[191:160] ^ c_s[95:64];
    c_s[31:0]   = key_r[159:128] ^ c_s[63:32];
  end

  // Round counter, state, rolling key and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_r     <= 4'd0;
      state_r   <= 128'h0;
      key_r     <= 256'h0;
      dataout_r <= 128'h0;
      done_r    <= 1'b0;
    end else begin
      case (rnd_r)
        4'd0: begin
          key_r   <= key;
          state_r <= datain ^ key[255:128];
          done_r  <= 1'b0;
          rnd_r   <= 4'd1;
        end
        NR: begin
          dataout_r <= sr_s ^ rk_s;
          done_r    <= 1'b1;
          rnd_r     <= 4'd0;
        end
        default: begin
          state_r <= mc_s ^ rk_s;
          key_r   <= {key_r[127:0], c_s};
          done_r  <= 1'b0;
          rnd_r   <= rnd_r + 4'd1;
        end
      endcase
    end
  end

  assign dataout = dataout_r;
  assign done    = done_r;

endmodule

// File: tb/tb_aes_cipher.sv
// tb_aes_cipher: self-checking bench for aes_cipher. Expected ciphertexts come
// from a byte-level AES-256 model whose S-box is derived from GF(2^8)
// inversion plus the affine map, alongside the FIPS-197 known answers.
module tb_aes_cipher;

  logic         clk;
  logic         rst_n;
  logic [255:0] key;
  logic [127:0] datain;
  logic [127:0] dataout;
  logic         done;

  int checks;
  int failures;

  logic [7:0] ref_sbox [256];

  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

  aes_cipher dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .datain  (datain),
    .dataout (dataout),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_subw(input logic [31:0] w);
    return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input logic [127:0] p);
    logic [31:0]  w [60];
    logic [31:0]  temp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = ref_subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        temp = ref_subw(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) s[i] = ref_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c + row] = s[4*((c + row) % 4) + row];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; report edges taken.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (done !== 1'b1 && cycles < budget);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    rst_n  = 1'b0;
    key    = rand256();
    datain = rand128();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dataout !== 128'h0) begin
      failures++;
      $display("FAIL reset_dataout got=%h want=%h", dataout, 128'h0);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    // Release at a falling edge: the next rising edge is the first load.
    key    = KAT_KEY;
    datain = KAT_PT;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, cyc);
    checks++;
    if (cyc != 15 || done !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_done got_edges=%0d done=%b want_edges=15", cyc, done);
    end
  endtask

  task automatic test_fips();
    int cyc;
    checks++;
    if (dataout !== KAT_CT) begin
      failures++;
      $display("FAIL fips_c3 got=%h want=%h", dataout, KAT_CT);
    end
    checks++;
    if (dataout !== ref_encrypt(KAT_KEY, KAT_PT)) begin
      failures++;
      $display("FAIL fips_c3_model got=%h want=%h", dataout, ref_encrypt(KAT_KEY, KAT_PT));
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_width got=%b want=0", done);
    end
    wait_done(40, cyc);
    checks++;
    if (cyc != 14 || done !== 1'b1 || dataout !== KAT_CT) begin
      failures++;
      $display("FAIL fips_repeat edges=%0d(want 14) done=%b got=%h want=%h", cyc, done, dataout, KAT_CT);
    end
  endtask

  task automatic test_zero();
    int cyc;
    key    = 256'h0;
    datain = 128'h0;
    wait_done(40, cyc);
    checks++;
    if (cyc != 15 || done !== 1'b1 || dataout !== ZERO_CT) begin
      failures++;
      $display("FAIL zero_vector edges=%0d done=%b got=%h want=%h", cyc, done, dataout, ZERO_CT);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [255:0] k;
    logic [127:0] p;
    for (int n = 0; n < 5; n++) begin
      k = rand256();
      p = rand128();
      key    = k;
      datain = p;
      wait_done(40, cyc);
      checks++;
      if (cyc != 15 || done !== 1'b1 || dataout !== ref_encrypt(k, p)) begin
        failures++;
        $display("FAIL random_%0d edges=%0d done=%b got=%h want=%h", n, cyc, done, dataout, ref_encrypt(k, p));
      end
    end
  endtask

  task automatic test_change_mid_block();
    int cyc;
    logic [255:0] k1, k2;
    logic [127:0] p1, p2;
    k1 = rand256(); p1 = rand128();
    k2 = rand256(); p2 = rand128();
    key = k1; datain = p1;
    tick();                              // load edge
    for (int i = 0; i < 4; i++) tick();  // rnd is now 5
    key = k2; datain = p2;
    wait_done(40, cyc);
    checks++;
    if (cyc != 10 || done !== 1'b1 || dataout !== ref_encrypt(k1, p1)) begin
      failures++;
      $display("FAIL change_rnd5_old edges=%0d(want 10) got=%h want=%h", cyc, dataout, ref_encrypt(k1, p1));
    end
    wait_done(40, cyc);
    checks++;
    if (cyc != 15 || done !== 1'b1 || dataout !== ref_encrypt(k2, p2)) begin
      failures++;
      $display("FAIL change_rnd5_new edges=%0d got=%h want=%h", cyc, dataout, ref_encrypt(k2, p2));
    end
  endtask

  task automatic test_reset_mid_block();
    int cyc;
    logic [255:0] k;
    logic [127:0] p;
    key = rand256(); datain = rand128();
    tick();                              // load edge
    for (int i = 0; i < 6; i++) tick();  // rnd is now 7
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dataout !== 128'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h done=%b want=0", dataout, done);
    end
    for (int i = 0; i < 2; i++) @(negedge clk);
    k = rand256(); p = rand128();
    key = k; datain = p;
    rst_n = 1'b1;
    wait_done(40, cyc);
    checks++;
    if (cyc != 15 || done !== 1'b1 || dataout !== ref_encrypt(k, p)) begin
      failures++;
      $display("FAIL reset_resume edges=%0d done=%b got=%h want=%h", cyc, done, dataout, ref_encrypt(k, p));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] want;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) begin
        key = KAT_KEY; datain = KAT_PT; want = KAT_CT;
      end else begin
        key = 256'h0; datain = 128'h0; want = ZERO_CT;
      end
      wait_done(40, cyc);
      checks++;
      if (cyc != 15 || done !== 1'b1 || dataout !== want) begin
        failures++;
        $display("FAIL back_to_back_%0d edges=%0d done=%b got=%h want=%h", n, cyc, done, dataout, want);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    key      = 256'h0;
    datain   = 128'h0;
    init_sbox();
    test_reset();
    test_fips();
    test_zero();
    test_random();
    test_change_mid_block();
    test_reset_mid_block();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
